// File: rtl/selrows_seq.sv
// Row-window sequencer: buffers a ROWS x COLS matrix, then streams rows first..last one per beat.
// Optional window range check and err pulse: define SELROWS_SEQ_CHECK_EN.
module selrows_seq #(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 8,
  parameter int RW    = $clog2(ROWS+1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0]   a,
  input  logic [RW-1:0]                      first,
  input  logic [RW-1:0]                      last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [COLS:1][WIDTH-1:0]           f,
  output logic [RW-1:0]                      out_row,
  output logic                               out_last,
`ifdef SELROWS_SEQ_CHECK_EN
  output logic                               err,
`endif
  output logic                               busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  typedef logic [COLS:1][WIDTH-1:0]         row_t;
  typedef logic [ROWS:1][COLS:1][WIDTH-1:0] mat_t;

  state_t        state_q, state_d;
  mat_t          buf_q;
  logic [RW-1:0] last_q;
  logic [RW-1:0] nxt_row;
  logic          accept;
  logic          legal;
  logic          adv;

  // Out-of-range index yields a zero row instead of an X read.
  function automatic row_t pick(input mat_t m, input logic [RW-1:0] idx);
    row_t r;
    r = '0;
    for (int i = 1; i <= ROWS; i++)
      if (idx == RW'(i)) r = m[i];
    return r;
  endfunction

`ifdef SELROWS_SEQ_CHECK_EN
  assign legal = (first != '0) && (first <= last) && (last <= RW'(ROWS));
`else
  assign legal = 1'b1;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign accept    = in_valid && in_ready;
  assign adv       = (state_q == STREAM) && out_ready && !out_last;
  assign nxt_row   = out_row + RW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && legal)       state_d = STREAM;
      STREAM:  if (out_ready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      f        <= '0;
      out_row  <= '0;
      out_last <= 1'b0;
      last_q   <= '0;
`ifdef SELROWS_SEQ_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SELROWS_SEQ_CHECK_EN
      err     <= accept && !legal;
`endif
      if (accept && legal) begin
        last_q   <= last;
        out_row  <= first;
        f        <= pick(a, first);
        out_last <= (first == last);
      end else if (adv) begin
        out_row  <= nxt_row;
        f        <= pick(buf_q, nxt_row);
        out_last <= (nxt_row == last_q);
      end
    end
  end

  // Matrix storage needs no reset; it is only read after a fresh load.
  always_ff @(posedge clk)
    if (accept && legal) buf_q <= a;

endmodule

// File: tb/tb_selrows_seq.sv
// Directed bench for selrows_seq with ROWS=4, COLS=2, WIDTH=8.
module tb_selrows_seq;
  localparam int ROWS = 4, COLS = 2, WIDTH = 8, RW = $clog2(ROWS+1);

  logic                             clk = 1'b0;
  logic                             reset;
  logic                             in_valid, in_ready;
  logic [ROWS:1][COLS:1][WIDTH-1:0] a;
  logic [RW-1:0]                    first, last;
  logic                             out_valid, out_ready;
  logic [COLS:1][WIDTH-1:0]         f;
  logic [RW-1:0]                    out_row;
  logic                             out_last, busy;
`ifdef SELROWS_SEQ_CHECK_EN
  logic                             err;
`endif

  int passed = 0, total = 0;

  selrows_seq #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .first(first), .last(last), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .out_row(out_row), .out_last(out_last),
`ifdef SELROWS_SEQ_CHECK_EN
    .err(err),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Matrix element a[r][c] = base + 10r + c
  task automatic load(input int base);
    for (int r = 1; r <= ROWS; r++)
      for (int c = 1; c <= COLS; c++)
        a[r][c] = 8'(base + 10*r + c);
  endtask

  function automatic logic [31:0] rowv(input int base, input int r);
    return {16'h0, 8'(base + 10*r + 2), 8'(base + 10*r + 1)};
  endfunction

  task automatic beat(input string tag, input int base, input int r, input logic lst);
    chk({tag, "_vld"},  32'(out_valid), 32'd1);
    chk({tag, "_f"},    32'(f), rowv(base, r));
    chk({tag, "_row"},  32'(out_row), 32'(r));
    chk({tag, "_last"}, 32'(out_last), 32'(lst));
    chk({tag, "_rdy"},  32'(in_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    first = '0; last = '0; a = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_rdy",  32'(in_ready), 32'd1);
    chk("rst_vld",  32'(out_valid), 32'd0);
    chk("rst_f",    32'(f), 32'd0);
    chk("rst_row",  32'(out_row), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Full window 1..4, no backpressure
    load(0); first = 1; last = 4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      beat("full", 0, r, r == 4);
      tick();
    end
    chk("full_end_vld", 32'(out_valid), 32'd0);
    chk("full_end_rdy", 32'(in_ready), 32'd1);
    chk("full_hold_f",  32'(f), rowv(0, 4));
    chk("full_hold_row", 32'(out_row), 32'd4);

    // Sub-window 2..3 with out_ready 1,0,0,1
    first = 2; last = 3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("sub2", 0, 2, 1'b0);
    tick();
    out_ready = 1'b0;
    beat("sub3", 0, 3, 1'b1);
    tick();
    beat("stall1", 0, 3, 1'b1);
    tick();
    beat("stall2", 0, 3, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("sub_end_vld", 32'(out_valid), 32'd0);
    chk("sub_end_rdy", 32'(in_ready), 32'd1);

    // Single row 4..4
    first = 4; last = 4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("single", 0, 4, 1'b1);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_vld_end", 32'(out_valid), 32'd0);

    // Input changes during stream are ignored; new matrix taken after out_last
    first = 1; last = 3; in_valid = 1'b1;
    tick();
    load(100); first = 2; last = 2;
    for (int r = 1; r <= 3; r++) begin
      beat("buf", 0, r, r == 3);
      tick();
    end
    chk("ovl_idle_vld", 32'(out_valid), 32'd0);
    chk("ovl_idle_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    beat("newmat", 100, 2, 1'b1);
    tick();
    chk("newmat_end", 32'(out_valid), 32'd0);

    // Reset after 2 beats of a 1..4 window
    load(0); first = 1; last = 4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    beat("pre_rst", 0, 3, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_vld",  32'(out_valid), 32'd0);
    chk("mid_rst_f",    32'(f), 32'd0);
    chk("mid_rst_row",  32'(out_row), 32'd0);
    chk("mid_rst_rdy",  32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    first = 3; last = 3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("post_rst", 0, 3, 1'b1);
    tick();
    chk("post_rst_end", 32'(out_valid), 32'd0);

`ifdef SELROWS_SEQ_CHECK_EN
    begin
      logic [RW-1:0] bf [3] = '{3, 0, 1};
      logic [RW-1:0] bl [3] = '{2, 1, 5};
      for (int i = 0; i < 3; i++) begin
        first = bf[i]; last = bl[i]; in_valid = 1'b1;
        chk("bad_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_vld", 32'(out_valid), 32'd0);
        chk("bad_idle", 32'(in_ready), 32'd1);
        tick();
        chk("bad_err_clr", 32'(err), 32'd0);
        chk("bad_vld2", 32'(out_valid), 32'd0);
      end
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
